// File: rtl/pow_iter_pkg.sv
// Shared types and the negative-exponent resolution table for pow_iter_unit.
package pow_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Outcome classes for a signed power with a negative exponent.
  typedef enum logic [1:0] {
    NR_ZERO  = 2'd0,  // |base| > 1: reciprocal truncates to 0
    NR_ONE   = 2'd1,  // result +1
    NR_MONE  = 2'd2,  // result -1 (all ones)
    NR_XZERO = 2'd3   // 0 ** negative: x result, reported as 0 with xflag
  } neg_res_e;

  // Resolve base ** exp for exp < 0 without iterating.
  function automatic neg_res_e neg_exp_result(
    input logic base_one,
    input logic base_mone,
    input logic base_zero,
    input logic exp_odd
  );
    neg_res_e r;
    if (base_one) begin
      r = NR_ONE;
    end else if (base_mone) begin
      r = exp_odd ? NR_MONE : NR_ONE;
    end else if (base_zero) begin
      r = NR_XZERO;
    end else begin
      r = NR_ZERO;
    end
    return r;
  endfunction

endpackage

// File: rtl/pow_mul_trunc.sv
// Combinational WIDTH x WIDTH multiply keeping the low WIDTH bits.
// The low half of a product is the same for signed and unsigned operands.
module pow_mul_trunc #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  // Self-determined WIDTH-bit context drops the upper product bits.
  always_comb begin
    p_o = a_i * b_i;
  end

endmodule

// File: rtl/pow_iter_unit.sv
// Sequential integer power unit: square-and-multiply, one exponent bit per
// cycle, result truncated to WIDTH bits, with LRM `**` corner cases
// (0**0 = 1, negative exponents resolved directly in signed mode).
module pow_iter_unit
  import pow_iter_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned EXP_WIDTH = 3,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_base,
  input  logic [EXP_WIDTH-1:0] in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_xflag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      sq_q, sq_d;
  logic [EXP_WIDTH-1:0]  e_q, e_d;
  logic [WIDTH-1:0]      res_q, res_d;
  logic                  xflag_q, xflag_d;

  logic [WIDTH-1:0]      mul_acc;
  logic [WIDTH-1:0]      mul_sq;
  logic                  exp_neg;
  neg_res_e              neg_res;

  pow_mul_trunc #(.WIDTH(WIDTH)) u_mul_acc (
    .a_i (acc_q),
    .b_i (sq_q),
    .p_o (mul_acc)
  );

  pow_mul_trunc #(.WIDTH(WIDTH)) u_mul_sq (
    .a_i (sq_q),
    .b_i (sq_q),
    .p_o (mul_sq)
  );

  // Classify the incoming operands for the direct-resolution paths.
  always_comb begin
    exp_neg = SIGNED && in_exp[EXP_WIDTH-1];
    neg_res = neg_exp_result(in_base == ONE, in_base == '1,
                             in_base == '0, in_exp[0]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      sq_q    <= '0;
      e_q     <= '0;
      res_q   <= '0;
      xflag_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      e_q     <= e_d;
      res_q   <= res_d;
      xflag_q <= xflag_d;
    end
  end

  // Next-state and datapath update: accept decode, iteration step, handoff.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    e_d     = e_q;
    res_d   = res_q;
    xflag_d = xflag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_exp == '0) begin
            res_d   = ONE;
            xflag_d = 1'b0;
            state_d = DONE;
          end else if (exp_neg) begin
            xflag_d = 1'b0;
            unique case (neg_res)
              NR_ONE:   res_d = ONE;
              NR_MONE:  res_d = '1;
              NR_XZERO: begin
                res_d   = '0;
                xflag_d = 1'b1;
              end
              NR_ZERO:  res_d = '0;
            endcase
            state_d = DONE;
          end else begin
            acc_d   = ONE;
            sq_d    = in_base;
            e_d     = in_exp;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (e_q[0]) begin
          acc_d = mul_acc;
        end
        sq_d = mul_sq;
        e_d  = e_q >> 1;
        // The last step always consumes the exponent MSB, so the final
        // product is taken straight from the multiplier output.
        if (e_d == '0) begin
          res_d   = e_q[0] ? mul_acc : acc_q;
          xflag_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          xflag_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and result outputs decoded from registered state.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    out_result = res_q;
    out_xflag  = xflag_q;
  end

endmodule

// File: tb/tb_pow_iter_unit.sv
// Directed bench for pow_iter_unit: unsigned instance (index 0) and signed
// instance (index 1), hand-computed results and latencies.
module tb_pow_iter_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [1:0]  out_xflag;
  logic [11:0] in_base [2];
  logic [2:0]  in_exp [2];
  logic [11:0] out_result [2];

  int unsigned n_checks;
  int unsigned n_pass;

  pow_iter_unit #(.WIDTH(12), .EXP_WIDTH(3), .SIGNED(1'b0)) u_dut_u (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid[0]),
    .in_ready   (in_ready[0]),
    .in_base    (in_base[0]),
    .in_exp     (in_exp[0]),
    .out_valid  (out_valid[0]),
    .out_ready  (out_ready[0]),
    .out_result (out_result[0]),
    .out_xflag  (out_xflag[0])
  );

  pow_iter_unit #(.WIDTH(12), .EXP_WIDTH(3), .SIGNED(1'b1)) u_dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid[1]),
    .in_ready   (in_ready[1]),
    .in_base    (in_base[1]),
    .in_exp     (in_exp[1]),
    .out_valid  (out_valid[1]),
    .out_ready  (out_ready[1]),
    .out_result (out_result[1]),
    .out_xflag  (out_xflag[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one operation on instance d, check latency, result and flag,
  // then drain it and check the return to IDLE.
  task automatic do_op(input int d, input logic [11:0] b, input logic [2:0] e,
                       input logic [11:0] res, input logic xf, input int lat,
                       input string tag);
    int unsigned cyc;
    check_eq({tag, ".in_ready"}, 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_base[d]  = b;
    in_exp[d]   = e;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    cyc = 0;
    while (!out_valid[d] && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, ".latency"}, cyc, 32'(lat));
    check_eq({tag, ".result"}, 32'(out_result[d]), 32'(res));
    check_eq({tag, ".xflag"}, 32'(out_xflag[d]), 32'(xf));
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check_eq({tag, ".idle_ready"}, 32'(in_ready[d]), 32'd1);
    check_eq({tag, ".idle_valid"}, 32'(out_valid[d]), 32'd0);
    check_eq({tag, ".idle_xflag"}, 32'(out_xflag[d]), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 2; i++) begin
      in_base[i] = '0;
      in_exp[i]  = '0;
    end

    // Reset state.
    #3;
    check_eq("rst.in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("rst.out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst.out_result", 32'(out_result[0]), 32'd0);
    check_eq("rst.out_xflag", 32'(out_xflag[0]), 32'd0);
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned instance.
    do_op(0, 12'h000, 3'd0, 12'h001, 1'b0, 0, "u_0pow0");
    do_op(0, 12'd3,   3'd5, 12'h0F3, 1'b0, 3, "u_3pow5");
    do_op(0, 12'd0,   3'd3, 12'h000, 1'b0, 2, "u_0pow3");
    do_op(0, 12'd5,   3'd7, 12'h12D, 1'b0, 3, "u_5pow7");
    do_op(0, 12'd2,   3'd7, 12'h080, 1'b0, 3, "u_2pow7");
    do_op(0, 12'd7,   3'd1, 12'h007, 1'b0, 1, "u_7pow1");
    do_op(0, 12'hFFF, 3'd4, 12'h001, 1'b0, 3, "u_fffpow4");

    // Signed instance: negative exponents and a negative base.
    do_op(1, 12'hFFF, 3'b101, 12'hFFF, 1'b0, 0, "s_m1powm3");
    do_op(1, 12'hFFF, 3'b110, 12'h001, 1'b0, 0, "s_m1powm2");
    do_op(1, 12'd2,   3'b110, 12'h000, 1'b0, 0, "s_2powm2");
    do_op(1, 12'd0,   3'b111, 12'h000, 1'b1, 0, "s_0powm1");
    do_op(1, 12'd1,   3'b100, 12'h001, 1'b0, 0, "s_1powm4");
    do_op(1, 12'hFFF, 3'b011, 12'hFFF, 1'b0, 2, "s_m1pow3");
    do_op(1, 12'hFFE, 3'b011, 12'hFF8, 1'b0, 2, "s_m2pow3");

    // Backpressure: 3**2 held in DONE while a new request is offered.
    in_valid[0] = 1'b1;
    in_base[0]  = 12'd3;
    in_exp[0]   = 3'd2;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("bp.valid_first", 32'(out_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_base[0]  = 12'd7;
      in_exp[0]   = 3'd1;
      @(posedge clk);
      #1;
      check_eq("bp.result", 32'(out_result[0]), 32'h009);
      check_eq("bp.valid", 32'(out_valid[0]), 32'd1);
      check_eq("bp.in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    check_eq("bp.release_ready", 32'(in_ready[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp.no_capture", 32'(out_valid[0]), 32'd0);
    end

    // Reset mid-RUN of 3**5.
    in_valid[0] = 1'b1;
    in_base[0]  = 12'd3;
    in_exp[0]   = 3'd5;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mr.in_run", 32'(in_ready[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr.out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("mr.out_result", 32'(out_result[0]), 32'd0);
    check_eq("mr.in_ready", 32'(in_ready[0]), 32'd1);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("mr.no_pulse", 32'(out_valid[0]), 32'd0);
    end
    do_op(0, 12'd2, 3'd3, 12'h008, 1'b0, 2, "mr_2pow3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
